// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared types and constants for the word-access memory
//               responder: FSM state encoding and bytes per word.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Responder FSM states; width fixed at 2 bits.
    typedef enum logic [1:0] {
        MEMR_IDLE = 2'd0,
        MEMR_WAIT = 2'd1,
        MEMR_XFER = 2'd2,
        MEMR_RESP = 2'd3
    } memr_state_t;

    // Bytes moved per word access; the transfer phase lasts this many cycles.
    localparam int WORD_BYTES = 4;

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Request/response channel between the CPU core (master) and
//               the data memory responder (slave). Request uses valid/ready,
//               response is a single-cycle pulse with no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [31:0]               req_addr;
    logic [8*WORD_BYTES-1:0]   req_wdata;
    logic                      resp_valid;
    logic [8*WORD_BYTES-1:0]   resp_rdata;
    logic                      resp_err;

    // Initiator side (CPU core).
    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    // Responder side (memory).
    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface : mem_responder_if
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Byte-addressed data memory answering word load/store
//               requests. Storage is a single-port byte array touched one
//               byte per cycle, so every access has a fixed duration:
//               LATENCY wait cycles, 4 transfer cycles, 1 response cycle.
//               Out-of-range addresses answer in the next cycle with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS     = 16,
    parameter int LATENCY       = 2,
    parameter int LITTLE_ENDIAN = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_responder_if.slave bus
);

    // Wait counter only needs to reach LATENCY-1; keep at least one bit so
    // the LATENCY=0 build still has a legal (unused) counter.
    localparam int                  c_WAIT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [1:0]          c_LAST_BYTE = 2'(WORD_BYTES - 1);
    localparam int                  c_DEPTH     = 2 ** ADDR_BITS;

    memr_state_t           r_state;
    memr_state_t           w_state_next;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [1:0]            r_byte_idx;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [31:0]           r_wdata;
    logic                  r_write;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [7:0]            r_mem [0:c_DEPTH-1];

    logic                  w_accept;
    logic                  w_addr_oob;
    logic                  w_resp;
    logic [ADDR_BITS-1:0]  w_mem_addr;
    logic [4:0]            w_lane;

    // LSB position of the word lane that byte k of the access maps to.
    function automatic logic [4:0] lane_lsb(input logic [1:0] k);
        if (LITTLE_ENDIAN != 0)
            return {k, 3'b000};
        else
            return {~k, 3'b000};
    endfunction

    assign w_accept   = bus.req_valid && (r_state == MEMR_IDLE);
    assign w_addr_oob = (bus.req_addr >> ADDR_BITS) != 32'd0;
    assign w_resp     = (r_state == MEMR_RESP);
    // Byte address wraps at the top of the array by truncation.
    assign w_mem_addr = r_addr + ADDR_BITS'(r_byte_idx);
    assign w_lane     = lane_lsb(r_byte_idx);

    assign bus.req_ready  = (r_state == MEMR_IDLE);
    assign bus.resp_valid = w_resp;
    assign bus.resp_err   = w_resp && r_err;
    assign bus.resp_rdata = (w_resp && !r_write) ? r_rdata : 32'd0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= MEMR_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state decode: IDLE -> (WAIT) -> XFER x4 -> RESP -> IDLE, or
    // IDLE -> RESP directly for an out-of-range address.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MEMR_IDLE: begin
                if (w_accept) begin
                    if (w_addr_oob)
                        w_state_next = MEMR_RESP;
                    else if (LATENCY > 0)
                        w_state_next = MEMR_WAIT;
                    else
                        w_state_next = MEMR_XFER;
                end
            end
            MEMR_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST)
                    w_state_next = MEMR_XFER;
            end
            MEMR_XFER: begin
                if (r_byte_idx == c_LAST_BYTE)
                    w_state_next = MEMR_RESP;
            end
            MEMR_RESP: w_state_next = MEMR_IDLE;
            default:   w_state_next = MEMR_IDLE;
        endcase
    end

    // Wait and byte counters; both come back to 0 on their own at phase end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_byte_idx <= 2'd0;
        end else begin
            if (r_state == MEMR_WAIT)
                r_wait_cnt <= (r_wait_cnt == c_WAIT_LAST) ? '0 : r_wait_cnt + 1'b1;
            if (r_state == MEMR_XFER)
                r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    // Request capture on accept, then byte-wise assembly of load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else if (w_accept) begin
            r_addr  <= bus.req_addr[ADDR_BITS-1:0];
            r_wdata <= bus.req_wdata;
            r_write <= bus.req_write;
            r_err   <= w_addr_oob;
            r_rdata <= 32'd0;
        end else if ((r_state == MEMR_XFER) && !r_write) begin
            r_rdata[w_lane +: 8] <= r_mem[w_mem_addr];
        end
    end

    // Store path: one byte per XFER cycle. Gated by rst so an abort does not
    // commit the byte of the cycle in which reset is sampled.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == MEMR_XFER) && r_write)
            r_mem[w_mem_addr] <= r_wdata[w_lane +: 8];
    end

    // Simulation backdoor: immediate byte access bypassing the FSM.
    task read_memory_byte(input logic [ADDR_BITS-1:0] address, output logic [7:0] data);
        data = r_mem[address];
    endtask

    task write_memory_byte(input logic [ADDR_BITS-1:0] address, input logic [7:0] data);
        r_mem[address] = data;
    endtask

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Three instances:
//               big-endian LATENCY=2, little-endian LATENCY=2 (both share
//               one request stream) and big-endian LATENCY=0 (own valid).
//               A countdown/byte-array model predicts every output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_main = 1'b0;
    logic        req_valid_fast = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder_if bus_be ();
    mem_responder_if bus_le ();
    mem_responder_if bus_l0 ();

    assign bus_be.req_valid = req_valid_main;
    assign bus_be.req_write = req_write;
    assign bus_be.req_addr  = req_addr;
    assign bus_be.req_wdata = req_wdata;
    assign bus_le.req_valid = req_valid_main;
    assign bus_le.req_write = req_write;
    assign bus_le.req_addr  = req_addr;
    assign bus_le.req_wdata = req_wdata;
    assign bus_l0.req_valid = req_valid_fast;
    assign bus_l0.req_write = req_write;
    assign bus_l0.req_addr  = req_addr;
    assign bus_l0.req_wdata = req_wdata;

    mem_responder #(.ADDR_BITS(16), .LATENCY(2), .LITTLE_ENDIAN(0)) dut_be (.clk(clk), .rst(rst), .bus(bus_be));
    mem_responder #(.ADDR_BITS(16), .LATENCY(2), .LITTLE_ENDIAN(1)) dut_le (.clk(clk), .rst(rst), .bus(bus_le));
    mem_responder #(.ADDR_BITS(16), .LATENCY(0), .LITTLE_ENDIAN(0)) dut_l0 (.clk(clk), .rst(rst), .bus(bus_l0));

    // ---------------- model ----------------
    int          m_left    [3];
    logic [31:0] m_rdata   [3];
    logic        m_err     [3];
    logic        m_write   [3];
    logic [15:0] m_addr    [3];
    logic [31:0] m_wdata   [3];
    int          m_accepts [3] = '{0, 0, 0};
    logic [7:0]  m_mem     [3][65536];

    function automatic int lat_of(input int d);
        return (d == 2) ? 0 : 2;
    endfunction

    function automatic int le_of(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic logic valid_of(input int d);
        return (d == 2) ? req_valid_fast : req_valid_main;
    endfunction

    function automatic logic [15:0] byte_addr(input logic [15:0] a, input int k);
        return a + 16'(k);
    endfunction

    function automatic logic [7:0] lane_of(input logic [31:0] w, input int k, input int le);
        logic [31:0] t;
        t = (le != 0) ? (w >> (8 * k)) : (w >> (24 - 8 * k));
        return t[7:0];
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [15:0] a);
        logic [31:0] word;
        word = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (le_of(d) != 0)
                word = word | (32'(m_mem[d][byte_addr(a, k)]) << (8 * k));
            else
                word = word | (32'(m_mem[d][byte_addr(a, k)]) << (24 - 8 * k));
        end
        return word;
    endfunction

    // m_left counts cycles until the responder is idle again; the response
    // is the cycle where it reads 1, and byte k of a store commits at the
    // edge closing the cycle where it reads 5-k.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_left[d] <= 0;
            end else if (m_left[d] == 0) begin
                if (valid_of(d)) begin
                    m_accepts[d] <= m_accepts[d] + 1;
                    m_addr[d]    <= req_addr[15:0];
                    m_wdata[d]   <= req_wdata;
                    m_write[d]   <= req_write;
                    if (req_addr[31:16] != 16'd0) begin
                        m_left[d]  <= 1;
                        m_err[d]   <= 1'b1;
                        m_rdata[d] <= 32'd0;
                    end else begin
                        m_left[d]  <= lat_of(d) + 5;
                        m_err[d]   <= 1'b0;
                        m_rdata[d] <= req_write ? 32'd0 : model_load(d, req_addr[15:0]);
                    end
                end
            end else begin
                if (m_write[d] && !m_err[d] && m_left[d] >= 2 && m_left[d] <= 5)
                    m_mem[d][byte_addr(m_addr[d], 5 - m_left[d])] <= lane_of(m_wdata[d], 5 - m_left[d], le_of(d));
                m_left[d] <= m_left[d] - 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic dut_ready(input int d);
        case (d)
            0:       return bus_be.req_ready;
            1:       return bus_le.req_ready;
            default: return bus_l0.req_ready;
        endcase
    endfunction

    function automatic logic dut_rvalid(input int d);
        case (d)
            0:       return bus_be.resp_valid;
            1:       return bus_le.resp_valid;
            default: return bus_l0.resp_valid;
        endcase
    endfunction

    function automatic logic [31:0] dut_rdata(input int d);
        case (d)
            0:       return bus_be.resp_rdata;
            1:       return bus_le.resp_rdata;
            default: return bus_l0.resp_rdata;
        endcase
    endfunction

    function automatic logic dut_rerr(input int d);
        case (d)
            0:       return bus_be.resp_err;
            1:       return bus_le.resp_err;
            default: return bus_l0.resp_err;
        endcase
    endfunction

    task automatic peek(input int d, input logic [15:0] a, output logic [7:0] b);
        case (d)
            0:       dut_be.read_memory_byte(a, b);
            1:       dut_le.read_memory_byte(a, b);
            default: dut_l0.read_memory_byte(a, b);
        endcase
    endtask

    task automatic check_byte(input string name, input int d, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] b;
        peek(d, a, b);
        check(name, {24'd0, b}, {24'd0, exp});
    endtask

    task automatic check_model_bytes(input int d, input logic [15:0] a, input int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            peek(d, byte_addr(a, k), b);
            check($sformatf("dut%0d mem[%04h] vs model", d, byte_addr(a, k)), {24'd0, b}, {24'd0, m_mem[d][byte_addr(a, k)]});
        end
    endtask

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("dut%0d req_ready", d), {31'd0, dut_ready(d)}, {31'd0, m_left[d] == 0});
                check($sformatf("dut%0d resp_valid", d), {31'd0, dut_rvalid(d)}, {31'd0, m_left[d] == 1});
                check($sformatf("dut%0d resp_rdata", d), dut_rdata(d), (m_left[d] == 1) ? m_rdata[d] : 32'd0);
                check($sformatf("dut%0d resp_err", d), {31'd0, dut_rerr(d)}, {31'd0, (m_left[d] == 1) && m_err[d]});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] cap_rdata0, cap_rdata1;
    logic        cap_err0, cap_err1;

    // One request on the shared LATENCY=2 stream; measures accept-to-response
    // distance on the big-endian instance and captures both responses.
    task automatic main_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int exp_lat);
        int n;
        @(negedge clk);
        req_valid_main = 1'b1;
        req_write      = w;
        req_addr       = a;
        req_wdata      = d;
        @(posedge clk);
        @(negedge clk);
        req_valid_main = 1'b0;
        n = 1;
        while (!bus_be.resp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("latency %s @%08h", w ? "store" : "load", a), 32'(n), 32'(exp_lat));
        cap_rdata0 = bus_be.resp_rdata;
        cap_rdata1 = bus_le.resp_rdata;
        cap_err0   = bus_be.resp_err;
        cap_err1   = bus_le.resp_err;
    endtask

    initial begin
        logic [7:0] snap [4];
        int         resp_cnt;
        int         acc0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset req_ready", {31'd0, bus_be.req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, bus_be.resp_valid}, 32'd0);
        check("reset resp_rdata", bus_be.resp_rdata, 32'd0);
        check("reset resp_err", {31'd0, bus_be.resp_err}, 32'd0);
        chk_en = 1'b1;

        // Store then load at 0x0040, both endiannesses
        main_req(1'b1, 32'h0000_0040, 32'h1122_3344, 7);
        check("store err", {31'd0, cap_err0}, 32'd0);
        check("store rdata", cap_rdata0, 32'd0);
        check_byte("be mem[40]", 0, 16'h0040, 8'h11);
        check_byte("be mem[41]", 0, 16'h0041, 8'h22);
        check_byte("be mem[42]", 0, 16'h0042, 8'h33);
        check_byte("be mem[43]", 0, 16'h0043, 8'h44);
        check_byte("le mem[40]", 1, 16'h0040, 8'h44);
        check_byte("le mem[41]", 1, 16'h0041, 8'h33);
        check_byte("le mem[43]", 1, 16'h0043, 8'h11);
        main_req(1'b0, 32'h0000_0040, 32'h0, 7);
        check("be load 40", cap_rdata0, 32'h1122_3344);
        check("le load 40", cap_rdata1, 32'h1122_3344);
        check("load err", {31'd0, cap_err0}, 32'd0);

        // Out-of-range load
        for (int k = 0; k < 4; k++) peek(0, 16'(k), snap[k]);
        main_req(1'b0, 32'h0001_0000, 32'h0, 1);
        check("oob err be", {31'd0, cap_err0}, 32'd1);
        check("oob err le", {31'd0, cap_err1}, 32'd1);
        check("oob rdata", cap_rdata0, 32'd0);
        for (int k = 0; k < 4; k++) check_byte($sformatf("oob unchanged[%0d]", k), 0, 16'(k), snap[k]);

        // Wrapping store/load at the top of the array
        main_req(1'b1, 32'h0000_FFFE, 32'hAABB_CCDD, 7);
        check("wrap store err", {31'd0, cap_err0}, 32'd0);
        check_byte("be mem[fffe]", 0, 16'hFFFE, 8'hAA);
        check_byte("be mem[ffff]", 0, 16'hFFFF, 8'hBB);
        check_byte("be mem[0000]", 0, 16'h0000, 8'hCC);
        check_byte("be mem[0001]", 0, 16'h0001, 8'hDD);
        check_byte("le mem[fffe]", 1, 16'hFFFE, 8'hDD);
        check_byte("le mem[0001]", 1, 16'h0001, 8'hAA);
        main_req(1'b0, 32'h0000_FFFE, 32'h0, 7);
        check("be load fffe", cap_rdata0, 32'hAABB_CCDD);
        check("le load fffe", cap_rdata1, 32'hAABB_CCDD);

        // Reset during byte k=2 of a store
        peek(0, 16'h0082, snap[0]);
        peek(0, 16'h0083, snap[1]);
        peek(1, 16'h0082, snap[2]);
        peek(1, 16'h0083, snap[3]);
        @(negedge clk);
        req_valid_main = 1'b1;
        req_write      = 1'b1;
        req_addr       = 32'h0000_0080;
        req_wdata      = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid_main = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort req_ready", {31'd0, bus_be.req_ready}, 32'd1);
        resp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_be.resp_valid || bus_le.resp_valid) resp_cnt++;
            @(negedge clk);
        end
        check("abort no response", 32'(resp_cnt), 32'd0);
        check_byte("abort be mem[80]", 0, 16'h0080, 8'hDE);
        check_byte("abort be mem[81]", 0, 16'h0081, 8'hAD);
        check_byte("abort be mem[82]", 0, 16'h0082, snap[0]);
        check_byte("abort be mem[83]", 0, 16'h0083, snap[1]);
        check_byte("abort le mem[80]", 1, 16'h0080, 8'hEF);
        check_byte("abort le mem[81]", 1, 16'h0081, 8'hBE);
        check_byte("abort le mem[82]", 1, 16'h0082, snap[2]);
        check_byte("abort le mem[83]", 1, 16'h0083, snap[3]);

        // LATENCY=0 with req_valid held high: stores every 6 cycles
        acc0 = m_accepts[2];
        req_write      = 1'b1;
        req_addr       = 32'h0000_0100;
        req_wdata      = 32'hC0DE_0000;
        req_valid_fast = 1'b1;
        resp_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_l0.resp_valid) resp_cnt++;
            req_addr  = 32'h0000_0100 + 32'(4 * (i + 1));
            req_wdata = 32'hC0DE_0000 + 32'(i + 1);
        end
        req_valid_fast = 1'b0;
        check("stream accepts", 32'(m_accepts[2] - acc0), 32'd4);
        check("stream responses", 32'(resp_cnt), 32'd4);
        repeat (8) @(negedge clk);
        check_byte("stream mem[118]", 2, 16'h0118, 8'hC0);
        check_byte("stream mem[11b]", 2, 16'h011B, 8'h06);
        check_byte("stream mem[14b]", 2, 16'h014B, 8'h12);
        for (int j = 0; j < 4; j++) check_model_bytes(2, 16'h0100 + 16'(24 * j), 4);

        // Whole-run memory agreement for the shared stream
        for (int d = 0; d < 2; d++) begin
            check_model_bytes(d, 16'h0040, 4);
            check_model_bytes(d, 16'hFFFE, 4);
            check_model_bytes(d, 16'h0080, 2);
        end

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog timeout");
    end

endmodule : tb_mem_responder
`default_nettype wire
